seq_ripple_adder: RTL
=====================

SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 2: bits added per clock cycle; WIDTH SHALL be an integer multiple of SLICE, and N = WIDTH/SLICE.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-008 The block SHALL have port sub, input, 1 bit: mode select, 0 = add, 1 = subtract.
REQ-009 The block SHALL have port in_valid, input, 1 bit: operands valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB; in subtract mode 1 means no borrow.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 out_valid SHALL be 1 only in DONE.
REQ-019 Accept: on a rising edge in IDLE with in_valid=1, the block SHALL register a, b XOR {WIDTH{sub}}, the carry (sub ? 1 : cin), and sub, then go to CALC with slice index 0.
REQ-020 In IDLE with in_valid=0, the block SHALL hold all state.
REQ-021 Each CALC edge SHALL ripple-add bits [i*SLICE +: SLICE] of the registered operands using the registered carry, SLICE full-adder stages in series.
REQ-022 Each CALC edge SHALL write those result bits into sum, update the carry register, and increment i.
REQ-023 On the edge that processes slice N-1, the block SHALL set cout to the final carry, set ovf to (carry into MSB) XOR (carry out of MSB), and go to DONE.
REQ-024 Latency SHALL be N rising edges from accept to out_valid=1 (4 for the defaults).
REQ-025 In DONE, sum, cout and ovf SHALL be stable while out_ready=0.
REQ-026 In DONE with out_ready=1, the block SHALL go to IDLE on that edge.
REQ-027 Throughput SHALL be one result per N+2 cycles at most; the block SHALL NOT accept new operands in DONE.
REQ-028 in_valid, a, b, cin and sub SHALL be ignored outside IDLE; changes mid-CALC SHALL NOT affect the result.
REQ-029 sum SHALL hold the previous result in IDLE; during CALC it holds a mix of new low slices and old high slices, and consumers use it only when out_valid=1.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH, with no internal widening beyond the carry bit.
REQ-031 When SLICE = WIDTH (N=1), the block SHALL complete in a single CALC cycle with identical FSM behaviour.

Reset
REQ-032 rst_n=0 SHALL immediately, without a clock, force: state IDLE, i=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1, and internal operand and carry registers to 0.
REQ-033 A reset asserted mid-CALC or in DONE SHALL abort the operation with no output pulse.
REQ-034 After release, the first operation SHALL behave as if from power-up.

Verification (WIDTH=8, SLICE=2)
REQ-035 Add a=0x5A, b=0x3C, cin=1, sub=0 -> sum=0x97, cout=0, ovf=1, out_valid rises exactly 4 edges after accept.
REQ-036 Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
REQ-037 Subtract a=0x10, b=0x20 (cin=1, ignored) -> sum=0xF0, cout=0, ovf=0; subtract a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
REQ-038 Back-pressure: out_ready=0 for 3 cycles in DONE -> out_valid stays 1 and sum/cout/ovf are unchanged; in_valid=1 throughout is not accepted until the cycle after the out_ready=1 edge.
REQ-039 rst_n pulsed low 2 cycles after accept -> outputs at reset values immediately, no out_valid; next operation 0x01+0x01 -> sum=0x02 after 4 edges.
REQ-040 Randomised sweep: 1000 operand/mode sets, including parameter sets (8,8), (16,4) and (12,3), SHALL match a reference {cout,sum} = a + (sub ? ~b+1 : b + cin) and a signed-overflow model.

Source files
------------

// File: rtl/seq_ripple_adder.sv
// rtl/seq_ripple_adder.sv - multi-cycle adder/subtractor, SLICE bits rippled per clock
module seq_ripple_adder #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;

   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] s_sl;
   logic             rc;
   logic             c_out;
   logic             c_msb;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // c_msb keeps the carry entering the top stage; only meaningful on the last slice
   always_comb begin
      a_sl  = opa[idx*SLICE +: SLICE];
      b_sl  = opb[idx*SLICE +: SLICE];
      s_sl  = '0;
      rc    = carry;
      c_msb = carry;
      for (int k = 0; k < SLICE; k++) begin
         c_msb   = rc;
         s_sl[k] = a_sl[k] ^ b_sl[k] ^ rc;
         rc      = (a_sl[k] & b_sl[k]) | (rc & (a_sl[k] ^ b_sl[k]));
      end
      c_out = rc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // subtraction is a + ~b + 1, so the carry-in is forced high
                  opa   <= a;
                  opb   <= b ^ {WIDTH{sub}};
                  carry <= sub | cin;
                  idx   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               sum[idx*SLICE +: SLICE] <= s_sl;
               carry                   <= c_out;
               if (idx == IW'(N - 1)) begin
                  cout  <= c_out;
                  ovf   <= c_out ^ c_msb;
                  idx   <= '0;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
